// File: rtl/pio_host_loader.sv
// Host-side initiator for the pio command interface: loads a program, configures and enables one
// state machine, then streams TX/RX words. `define PIO_LOADER_PRELOAD_EN adds the preload sequence.
module pio_host_loader #(
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  machine,
  input  logic [5:0]  plen,
  input  logic [23:0] div,
  input  logic [31:0] pin_grps,
  input  logic [4:0]  sideset_bits,
`ifdef PIO_LOADER_PRELOAD_EN
  input  logic [31:0] preload,
`endif
  output logic [4:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din,
  input  logic [31:0] dout,
  input  logic [3:0]  full,
  input  logic [3:0]  empty,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  output logic        m_valid,
  output logic [31:0] m_data,
  input  logic        m_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Handshakes: a word moves when valid and ready are both high at a rising edge. s_ready may
  // depend on s_valid; m_valid/m_data stay stable until m_ready is sampled high.

  localparam logic [3:0] A_NONE  = 4'd0;
  localparam logic [3:0] A_INSTR = 4'd1;
  localparam logic [3:0] A_PEND  = 4'd2;
  localparam logic [3:0] A_PULL  = 4'd3;
  localparam logic [3:0] A_PUSH  = 4'd4;
  localparam logic [3:0] A_GRPS  = 4'd5;
  localparam logic [3:0] A_EN    = 4'd6;
  localparam logic [3:0] A_DIV   = 4'd7;
  localparam logic [3:0] A_SIDES = 4'd8;
  localparam logic [3:0] A_IMM   = 4'd9;
  localparam logic [2:0] GAP_C   = 3'(GAP);

  typedef enum logic [3:0] {
    S_IDLE, S_PRIME, S_LOAD, S_PEND, S_DIV, S_GRPS, S_SIDES,
    S_PRE_PUSH, S_PRE_IMM1, S_PRE_IMM2, S_EN, S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [2:0]  gap_q, gap_d;
  logic        stop_q, stop_d;
  logic        cap_q, cap_d;
  logic        err_q, err_d;
  logic [1:0]  machine_q, machine_d;
  logic [5:0]  plen_q, plen_d;
  logic [23:0] div_q, div_d;
  logic [31:0] grps_q, grps_d;
  logic [4:0]  sides_q, sides_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
`ifdef PIO_LOADER_PRELOAD_EN
  logic [31:0] preload_q, preload_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      stop_q    <= 1'b0;
      cap_q     <= 1'b0;
      err_q     <= 1'b0;
      machine_q <= '0;
      plen_q    <= '0;
      div_q     <= '0;
      grps_q    <= '0;
      sides_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
`ifdef PIO_LOADER_PRELOAD_EN
      preload_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      stop_q    <= stop_d;
      cap_q     <= cap_d;
      err_q     <= err_d;
      machine_q <= machine_d;
      plen_q    <= plen_d;
      div_q     <= div_d;
      grps_q    <= grps_d;
      sides_q   <= sides_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
`ifdef PIO_LOADER_PRELOAD_EN
      preload_q <= preload_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    stop_d    = stop_q;
    cap_d     = 1'b0;
    err_d     = 1'b0;
    machine_d = machine_q;
    plen_d    = plen_q;
    div_d     = div_q;
    grps_d    = grps_q;
    sides_d   = sides_q;
`ifdef PIO_LOADER_PRELOAD_EN
    preload_d = preload_q;
`endif
    action    = A_NONE;
    index     = '0;
    din       = '0;
    prog_addr = '0;
    s_ready   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    // RX capture lands one cycle after the PULL, when the pio presents the popped word.
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (cap_q) begin
      m_valid_d = 1'b1;
      m_data_d  = dout;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (plen == 6'd0 || plen > 6'd32) begin
            err_d = 1'b1;
          end else begin
            machine_d = machine;
            plen_d    = plen;
            div_d     = div;
            grps_d    = pin_grps;
            sides_d   = sideset_bits;
`ifdef PIO_LOADER_PRELOAD_EN
            preload_d = preload;
`endif
            state_d   = S_PRIME;
          end
        end
      end
      S_PRIME: begin
        busy    = 1'b1;
        idx_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        busy      = 1'b1;
        action    = A_INSTR;
        index     = idx_q[4:0];
        din       = {16'h0, prog_data};
        prog_addr = idx_q[4:0] + 5'd1;
        if (idx_q == plen_q - 6'd1) state_d = S_PEND;
        else                        idx_d   = idx_q + 6'd1;
      end
      S_PEND: begin
        busy    = 1'b1;
        action  = A_PEND;
        din     = 32'(plen_q - 6'd1);
        state_d = S_DIV;
      end
      S_DIV: begin
        busy    = 1'b1;
        action  = A_DIV;
        din     = {8'h0, div_q};
        state_d = S_GRPS;
      end
      S_GRPS: begin
        busy    = 1'b1;
        action  = A_GRPS;
        din     = grps_q;
        state_d = S_SIDES;
      end
      S_SIDES: begin
        busy    = 1'b1;
        action  = A_SIDES;
        din     = {27'h0, sides_q};
`ifdef PIO_LOADER_PRELOAD_EN
        state_d = S_PRE_PUSH;
`else
        state_d = S_EN;
`endif
      end
`ifdef PIO_LOADER_PRELOAD_EN
      S_PRE_PUSH: begin
        busy = 1'b1;
        if (gap_q != 3'd0) gap_d = gap_q - 3'd1;
        else begin
          action  = A_PUSH;
          din     = preload_q;
          gap_d   = GAP_C;
          state_d = S_PRE_IMM1;
        end
      end
      S_PRE_IMM1: begin
        busy = 1'b1;
        if (gap_q != 3'd0) gap_d = gap_q - 3'd1;
        else begin
          action  = A_IMM;
          din     = 32'h0000_8080;
          gap_d   = GAP_C;
          state_d = S_PRE_IMM2;
        end
      end
      S_PRE_IMM2: begin
        busy = 1'b1;
        if (gap_q != 3'd0) gap_d = gap_q - 3'd1;
        else begin
          action  = A_IMM;
          din     = 32'h0000_A0C7;
          gap_d   = GAP_C;
          state_d = S_EN;
        end
      end
`endif
      S_EN: begin
        busy = 1'b1;
        if (gap_q != 3'd0) gap_d = gap_q - 3'd1;
        else begin
          action  = A_EN;
          din     = 32'(1) << machine_q;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        done = 1'b1;
        if (stop) stop_d = 1'b1;
        if (gap_q != 3'd0) begin
          gap_d = gap_q - 3'd1;
        end else if (stop_q && !cap_q) begin
          action  = A_EN;
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else if (!empty[machine_q] && !m_valid_q && !cap_q) begin
          action = A_PULL;
          cap_d  = 1'b1;
          gap_d  = GAP_C;
        end else if (s_valid && !full[machine_q]) begin
          action  = A_PUSH;
          din     = s_data;
          s_ready = 1'b1;
          gap_d   = GAP_C;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mindex  = machine_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pio_host_loader.sv
// Directed bench for pio_host_loader: table-driven load/config sequence plus hand-written RUN,
// stop, error and reset sequences. Build with +define+PIO_LOADER_PRELOAD_EN to cover preload.
module tb_pio_host_loader;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [1:0]  machine;
  logic [5:0]  plen;
  logic [23:0] div;
  logic [31:0] pin_grps;
  logic [4:0]  sideset_bits;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  action;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic [31:0] din, dout;
  logic [3:0]  full, empty;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [31:0] s_data, m_data;
  logic        busy, done, err;
`ifdef PIO_LOADER_PRELOAD_EN
  logic [31:0] preload;
`endif

  pio_host_loader #(.GAP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .machine(machine), .plen(plen),
    .div(div), .pin_grps(pin_grps), .sideset_bits(sideset_bits),
`ifdef PIO_LOADER_PRELOAD_EN
    .preload(preload),
`endif
    .prog_addr(prog_addr), .prog_data(prog_data), .action(action), .index(index),
    .mindex(mindex), .din(din), .dout(dout), .full(full), .empty(empty),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // instruction ROM with one cycle read latency
  logic [15:0] rom [32];
  always_ff @(posedge clk) prog_data <= rom[prog_addr];

  int rdy_cnt = 0;
  always @(negedge clk) if (s_ready === 1'b1) rdy_cnt++;

  typedef struct {
    logic [3:0]  act;
    logic [4:0]  idx;
    logic [31:0] d;
    logic [4:0]  pa;
    logic        bsy;
    logic        dn;
  } vec_t;
  vec_t vecs[$];

  int n_vec = 0;
  int n_err = 0;

  function automatic void add(logic [3:0] a, logic [4:0] ix, logic [31:0] d, logic [4:0] pa,
                              logic b, logic dn);
    vec_t v;
    v.act = a; v.idx = ix; v.d = d; v.pa = pa; v.bsy = b; v.dn = dn;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic gap_none(input int n);
    for (int g = 0; g < n; g++) add(4'd0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int base;
    logic [5:0] bad_plen [2];
    bad_plen[0] = 6'd0;
    bad_plen[1] = 6'd33;
    for (int i = 0; i < 32; i++) rom[i] = 16'h6000 + 16'(i * 16'h0111);

    // expected load/config sequence, cycles T+1 onward
    add(4'd0, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) add(4'd1, 5'(i), {16'h0, rom[i]}, 5'(i + 1), 1'b1, 1'b0);
    add(4'd2, 5'd0, 32'd6, 5'd0, 1'b1, 1'b0);
    add(4'd7, 5'd0, 32'h280, 5'd0, 1'b1, 1'b0);
    add(4'd5, 5'd0, 32'h2000_0000, 5'd0, 1'b1, 1'b0);
    add(4'd8, 5'd0, 32'd1, 5'd0, 1'b1, 1'b0);
`ifdef PIO_LOADER_PRELOAD_EN
    add(4'd4, 5'd0, 32'd10, 5'd0, 1'b1, 1'b0);
    gap_none(2);
    add(4'd9, 5'd0, 32'h8080, 5'd0, 1'b1, 1'b0);
    gap_none(2);
    add(4'd9, 5'd0, 32'hA0C7, 5'd0, 1'b1, 1'b0);
    gap_none(2);
`endif
    add(4'd6, 5'd0, 32'd1, 5'd0, 1'b1, 1'b0);
    add(4'd0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b1);

    reset = 1'b1; start = 1'b0; stop = 1'b0; machine = 2'd0; plen = 6'd0; div = '0;
    pin_grps = '0; sideset_bits = '0; dout = '0; full = 4'b1110; empty = 4'b0001;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
`ifdef PIO_LOADER_PRELOAD_EN
    preload = 32'd10;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    smp();
    chk("reset action", action, 0);
    chk("reset din", din, 0);
    chk("reset flags", {busy, done, err, s_ready, m_valid}, 0);
    chk("reset mindex/prog_addr", {mindex, prog_addr}, 0);

    // load sequence
    cyc();
    start = 1'b1; plen = 6'd7; machine = 2'd0; div = 24'h280; pin_grps = 32'h2000_0000;
    sideset_bits = 5'd1;
    cyc();
    start = 1'b0;
    foreach (vecs[i]) begin
      smp();
      chk($sformatf("seq[%0d] action", i), action, vecs[i].act);
      chk($sformatf("seq[%0d] index", i), index, vecs[i].idx);
      chk($sformatf("seq[%0d] din", i), din, vecs[i].d);
      chk($sformatf("seq[%0d] prog_addr", i), prog_addr, vecs[i].pa);
      chk($sformatf("seq[%0d] busy/done", i), {busy, done}, {vecs[i].bsy, vecs[i].dn});
    end

    // two pushes separated by the gap
    cyc();
    base = rdy_cnt;
    s_valid = 1'b1; s_data = 32'd2;
    smp(); chk("push2 action", action, 4); chk("push2 din", din, 2); chk("push2 rdy", s_ready, 1);
    cyc(); s_data = 32'd4;
    smp(); chk("gap1 action", action, 0); chk("gap1 rdy", s_ready, 0);
    cyc();
    smp(); chk("gap2 action", action, 0); chk("gap2 rdy", s_ready, 0);
    cyc();
    smp(); chk("push4 action", action, 4); chk("push4 din", din, 4); chk("push4 rdy", s_ready, 1);
    cyc(); s_valid = 1'b0;
    cyc();
    cyc();
    chk("s_ready pulses", rdy_cnt - base, 2);

    // TX FIFO full stalls the push
    full = 4'b1111; s_valid = 1'b1; s_data = 32'd7;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("full stall[%0d] action", k), action, 0);
      chk($sformatf("full stall[%0d] rdy", k), s_ready, 0);
      cyc();
    end
    full = 4'b1110;
    smp(); chk("push7 action", action, 4); chk("push7 din", din, 7); chk("push7 rdy", s_ready, 1);
    cyc(); s_valid = 1'b0;
    cyc();
    cyc();

    // RX has priority over a waiting TX word
    empty = 4'b0000; dout = 32'hDEAD_BEEF; s_valid = 1'b1; s_data = 32'd9;
    smp(); chk("pull action", action, 3); chk("pull rdy", s_ready, 0); chk("pull din", din, 0);
    cyc(); empty = 4'b0001;
    smp(); chk("pull gap1 action", action, 0);
    cyc();
    smp(); chk("pull gap2 action", action, 0);
    chk("m_valid after pull", m_valid, 1); chk("m_data", m_data, 32'hDEAD_BEEF);
    cyc();
    smp(); chk("push9 action", action, 4); chk("push9 din", din, 9); chk("push9 rdy", s_ready, 1);
    cyc(); s_valid = 1'b0; m_ready = 1'b1;
    smp(); chk("m_valid held", m_valid, 1);
    cyc(); m_ready = 1'b0;
    smp(); chk("m_valid drop", m_valid, 0); chk("m_data hold", m_data, 32'hDEAD_BEEF);
    cyc();

    // stop arriving with a push waits out the gap
    s_valid = 1'b1; s_data = 32'd11; stop = 1'b1;
    smp(); chk("push11 action", action, 4); chk("push11 din", din, 11);
    cyc(); s_valid = 1'b0; stop = 1'b0;
    smp(); chk("stop gap1 action", action, 0); chk("stop gap1 done", done, 1);
    cyc();
    smp(); chk("stop gap2 action", action, 0);
    cyc();
    smp(); chk("stop en action", action, 6); chk("stop en din", din, 0); chk("stop en done", done, 1);
    cyc();
    smp(); chk("idle done", done, 0); chk("idle action", action, 0); chk("idle busy", busy, 0);

    // invalid program lengths
    foreach (bad_plen[j]) begin
      cyc(); start = 1'b1; plen = bad_plen[j];
      cyc(); start = 1'b0;
      smp();
      chk($sformatf("err plen=%0d", bad_plen[j]), err, 1);
      chk($sformatf("err plen=%0d busy", bad_plen[j]), busy, 0);
      chk($sformatf("err plen=%0d action", bad_plen[j]), action, 0);
      cyc();
      smp();
      chk($sformatf("err plen=%0d pulse end", bad_plen[j]), err, 0);
      chk($sformatf("err plen=%0d still idle", bad_plen[j]), busy, 0);
    end

    // reset during LOAD
    cyc(); start = 1'b1; plen = 6'd7; machine = 2'd2;
    cyc(); start = 1'b0;
    smp(); chk("rst seq mindex", mindex, 2); chk("rst seq busy", busy, 1);
    cyc();
    cyc(); reset = 1'b1;
    smp(); chk("rst seq load action", action, 1);
    cyc(); reset = 1'b0;
    smp();
    chk("abort action", action, 0);
    chk("abort din/index", {din, index}, 0);
    chk("abort mindex/prog_addr", {mindex, prog_addr}, 0);
    chk("abort flags", {busy, done, err, s_ready, m_valid}, 0);
    chk("abort m_data", m_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pio_host_loader.md
Name: pio_host_loader

Overview:
- Host-side initiator for the pio block's action/din/index/mindex command interface; the pio is the responder.
- On start, copies a program from an external instruction ROM into the pio and issues the wrap, divider, pin-group and side-set configuration, then enables one state machine.
- While running, streams words from a valid/ready source into that machine's TX FIFO and drains its RX FIFO to a valid/ready sink.
- Replaces hand-sequenced bench tasks in simulation and on hardware.

Parameters:
- GAP, 2, number of NONE cycles inserted after every PUSH, PULL or IMM action (range 0..7).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins the load sequence (IDLE only)
- stop  in  1  one-cycle pulse; disables the machine and returns to IDLE (RUN only)
- machine  in  2  state machine index, latched at start
- plen  in  6  program length, valid range 1..32
- div  in  24  clock divider value
- pin_grps  in  32  pin group word
- sideset_bits  in  5  side-set bit count
- prog_addr  out  5  instruction ROM address; ROM read latency is 1 cycle
- prog_data  in  16  instruction ROM data
- action  out  4  pio action code
- index  out  5  pio instruction index
- mindex  out  2  pio machine index
- din  out  32  pio data
- dout  in  32  pio read data
- full  in  4  pio TX FIFO full flags
- empty  in  4  pio RX FIFO empty flags
- s_valid  in  1  TX stream valid
- s_data  in  32  TX stream data
- s_ready  out  1  TX stream accept
- m_valid  out  1  RX word valid
- m_data  out  32  RX word
- m_ready  in  1  RX sink accept
- busy  out  1  high from PRIME through EN
- done  out  1  high while in RUN
- err  out  1  one-cycle pulse on an invalid start

Behaviour:
- Action codes: NONE 0, INSTR 1, PEND 2, PULL 3, PUSH 4, GRPS 5, EN 6, DIV 7, SIDES 8, IMM 9.
- Every non-NONE action is driven for exactly one cycle.
- index and din are 0 whenever they carry no meaning.
- mindex holds the latched machine value from start onward.
- Reset: action, index, mindex, din, prog_addr all 0; s_ready, m_valid, busy, done, err all 0; m_data 0; state IDLE.
- Reset mid-sequence aborts immediately. The machine is not disabled by the loader in this case; the pio reset handles that.
- IDLE:
  - start with plen==0 or plen>32: pulse err, stay in IDLE.
  - Valid start sampled at edge T: latch machine, plen, div, pin_grps and sideset_bits.
- PRIME (cycle T+1): prog_addr=0, action NONE.
- LOAD, cycles T+2 .. T+1+plen:
  - action=INSTR, index=i, din={16'h0,prog_data}.
  - prog_addr=i+1 in the same cycle, so one instruction is written per cycle.
- Configuration, one cycle each, in this order:
  - PEND with din=plen-1
  - DIV with din={8'h0,div}
  - GRPS with din=pin_grps
  - SIDES with din={27'h0,sideset_bits}
  - EN with din=1<<machine
- Entering RUN:
  - busy falls after the EN cycle.
  - done rises the cycle after EN.
- RUN arbitration, evaluated in cycles where no action or gap is active:
  - RX has priority: if !empty[machine] and m_valid==0, issue PULL. Capture dout into m_data one cycle after PULL; m_valid rises with that capture.
  - Otherwise, if s_valid and !full[machine], issue PUSH with din=s_data and assert s_ready for that same single cycle.
  - Each PUSH or PULL is followed by GAP NONE cycles. s_ready is 0 during gaps.
- m_valid falls on the cycle after m_valid&m_ready is sampled.
- stop in RUN:
  - Any in-progress gap and pending capture complete first.
  - Then issue EN with din=0, go to IDLE, done falls.
- start outside IDLE and stop outside RUN are ignored.

Optional Feature:
- Macro: PIO_LOADER_PRELOAD_EN.
- When defined:
  - Adds input port preload (32 bits).
  - After SIDES and before EN, issue in order, each followed by GAP NONE cycles:
    - PUSH with din=preload
    - IMM with din=16'h8080 (PULL)
    - IMM with din=16'hA0C7 (MOV ISR,OSR)
  - busy stays high throughout.
  - Used for PWM-style period setup.
- When undefined: no preload port; SIDES is followed directly by EN.

Test Plan:
- plen=7, machine=0, div=24'h280, pin_grps=32'h20000000, sideset_bits=1, start at T:
  - INSTR index 0..6 in cycles T+2..T+8 with ROM contents.
  - PEND din=6, DIV din=0x280, GRPS, SIDES din=1, EN din=1 at T+13.
  - done=1 at T+14.
- RUN with s_data 2 then 4, full=0, GAP=2: PUSH din=2, two NONE cycles, then PUSH din=4; s_ready pulses exactly twice.
- full[0]=1 with s_valid=1: no PUSH and s_ready=0 until full drops; the push then occurs in the next free cycle.
- empty[0]=0, dout=0xDEADBEEF, s_valid=1 simultaneously: PULL wins; m_data=0xDEADBEEF with m_valid high one cycle after PULL; the PUSH follows after the gap.
- start with plen=0: err pulses once, no action issued. Separately, reset asserted during LOAD: all outputs 0 next cycle.
- PIO_LOADER_PRELOAD_EN defined, preload=10: after SIDES, sequence PUSH 10, IMM 0x8080, IMM 0xA0C7, each followed by 2 NONE cycles, then EN.
